fma_operand_feeder: RTL
=======================

Name: fma_operand_feeder

Overview:
- Initiator (sending) side of the FMA operand handshake.
- Buffers host-supplied operand pairs in a small FIFO and presents them to the FMA on float_0/float_1 with req/busy flow control.
- Keeps exactly one pair in flight: sends one pair, then waits for the FMA answer before sending the next.
- After vec_len pairs, returns the final accumulated answer to the host with sticky overflow/underflow flags; a watchdog flags a hung FMA.

Parameters:
FP, 32, floating point word width (IEEE single bits, not shortreal)
DEPTH, 4, operand-pair FIFO depth (power of 2)
LEN_BITS, 4, width of vector-length field
TIMEOUT, 64, max cycles waiting for an FMA answer

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
push_in  input  1  host writes op_a_in/op_b_in into FIFO
op_a_in  input  FP  operand A (multiplicand)
op_b_in  input  FP  operand B (multiplier)
vec_len_in  input  LEN_BITS  pairs per accumulation; sampled on IDLE->ISSUE
full_out  output  1  FIFO full
float_0_req_out  output  1  request, operand 0 valid
float_1_req_out  output  1  request, operand 1 valid (always equal to float_0_req_out)
float_0_out  output  FP  operand 0 = FIFO head A
float_1_out  output  FP  operand 1 = FIFO head B
fma_busy_in  input  1  FMA cannot accept
fma_ready_answer_in  input  1  FMA answer valid
fma_answer_in  input  FP  FMA answer
fma_overflow_in  input  1  FMA overflow for this answer
fma_underflow_in  input  1  FMA underflow for this answer
result_valid_out  output  1  one-cycle pulse, final answer valid
result_out  output  FP  final answer (held until next result)
overflow_out  output  1  sticky OR over the vector
underflow_out  output  1  sticky OR over the vector
timeout_out  output  1  watchdog fired (sticky until rst)
busy_out  output  1  state != IDLE

Behaviour:
- Reset: rst is asynchronous; all outputs are 0; FIFO is emptied; state is IDLE; counters are 0. Reset asserted mid-operation aborts immediately, with reqs low in the same cycle.

FIFO
- Push accepted when push_in=1 and not full.
- A push while full is dropped, even if a pop occurs in the same cycle.
- Pop occurs on a transfer.
- float_0_out/float_1_out are driven from the FIFO head and remain stable while req is high.

Handshake
- A transfer occurs at a rising edge where float_0_req_out=1 and fma_busy_in=0.
- req is asserted only in ISSUE with the FIFO non-empty.
- req drops the cycle after a transfer.

States
- IDLE: if the FIFO is non-empty, sample vec_len_in (0 treated as 1), clear pair_cnt and sticky flags, then go to ISSUE.
- ISSUE: on a transfer, pair_cnt++, clear the timer, go to WAIT. If the FIFO is empty, remain in ISSUE with req low.
- WAIT: timer++ each cycle.
  - On fma_ready_answer_in=1: OR the flags into the sticky registers and capture fma_answer_in. If pair_cnt==len, go to DELIVER; otherwise go to ISSUE.
  - If the timer reaches TIMEOUT-1 with no answer, set timeout_out and go to ERROR.
  - An answer arriving in the same cycle as the timeout is accepted (answer wins).
- DELIVER: result_valid_out=1 for exactly one cycle with result_out and flags valid; go to IDLE.
- ERROR: reqs low; remain until rst.

Other rules
- fma_ready_answer_in outside WAIT is ignored.
- Latency: a push into an empty FIFO in IDLE causes req to rise on the 2nd rising edge after the push edge.
- pair_cnt is LEN_BITS+1 wide, so len=2^LEN_BITS-1 does not wrap.

Decomposition:
- Package fma_pkg: FP, EXPBITS, MANBITS, bool_e, and feeder_state_e {IDLE, ISSUE, WAIT, DELIVER, ERROR}.
- Sub-module fma_operand_fifo (2*FP wide, DEPTH deep, push/pop/full/empty/head).
- FSM, counters and sticky flags live in fma_operand_feeder.

Test Plan:
- Single pair, vec_len=1, A=0x40000000 (2.0), B=0x40400000 (3.0); FMA answers 0x40C00000 after 5 cycles -> result_valid_out pulses once, result_out=0x40C00000, flags 0.
- vec_len=3, three pairs; underflow only on the 2nd answer -> exactly one result pulse after the 3rd answer, underflow_out=1, overflow_out=0; reqs never high during WAIT.
- fma_busy_in held high 10 cycles while req is high -> float_0_out/float_1_out stable all 10 cycles, no pop, transfer on the first busy=0 edge.
- Push 5 pairs back-to-back with DEPTH=4 and the FSM stalled -> full_out=1 after the 4th push, 5th dropped; exactly 4 pairs transferred.
- No FMA answer -> timeout_out=1 at TIMEOUT cycles in WAIT, busy_out stays 1, no result pulse; an answer in the same cycle as the timeout -> accepted, no timeout.
- rst asserted mid-WAIT, asynchronous -> all outputs 0 before the next edge, FIFO empty; a subsequent push restarts normally.

Source files
------------

// File: rtl/fma_pkg.sv
// Shared constants and types for the FMA operand feeder.
// Word geometry follows IEEE-754 single precision.
package fma_pkg;

    localparam int FP      = 32;
    localparam int EXPBITS = 8;
    localparam int MANBITS = 23;

    typedef enum logic {
        FALSE = 1'b0,
        TRUE  = 1'b1
    } bool_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        DELIVER = 3'd3,
        ERROR   = 3'd4
    } feeder_state_e;

endpackage

// File: rtl/fma_operand_feeder_if.sv
// Operand/answer handshake between the feeder (master) and the FMA (slave).
// Signal names carry the direction as seen from the feeder.
interface fma_operand_feeder_if #(
    parameter int FP = 32
);
    logic          float_0_req_out;
    logic          float_1_req_out;
    logic [FP-1:0] float_0_out;
    logic [FP-1:0] float_1_out;
    logic          fma_busy_in;
    logic          fma_ready_answer_in;
    logic [FP-1:0] fma_answer_in;
    logic          fma_overflow_in;
    logic          fma_underflow_in;

    modport master (
        output float_0_req_out, float_1_req_out, float_0_out, float_1_out,
        input  fma_busy_in, fma_ready_answer_in, fma_answer_in,
               fma_overflow_in, fma_underflow_in
    );

    modport slave (
        input  float_0_req_out, float_1_req_out, float_0_out, float_1_out,
        output fma_busy_in, fma_ready_answer_in, fma_answer_in,
               fma_overflow_in, fma_underflow_in
    );
endinterface

// File: rtl/fma_operand_feeder_fifo.sv
// Operand-pair FIFO: DEPTH entries of W bits, head visible without a pop.
// Full/empty are registered so they are stable for the whole cycle.
module fma_operand_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [AW:0]   count_s;
    logic          full_r;
    logic          empty_r;
    logic          wr_s;
    logic          rd_s;

    // A push is gated by the registered full flag, so it is dropped even when a pop coincides
    always_comb begin
        wr_s = push && !full_r;
        rd_s = pop && !empty_r;
        case ({wr_s, rd_s})
            2'b10:   count_s = count_r + (AW+1)'(1);
            2'b01:   count_s = count_r - (AW+1)'(1);
            default: count_s = count_r;
        endcase
    end

    // Storage, pointers and occupancy flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (wr_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (rd_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_s;
            full_r  <= (count_s == FULL_CNT);
            empty_r <= (count_s == {(AW+1){1'b0}});
        end
    end

    assign full  = full_r;
    assign empty = empty_r;
    assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/fma_operand_feeder.sv
// Feeds buffered operand pairs to an FMA one at a time, accumulates sticky
// flags over a vector and returns the final answer; a watchdog traps a hung FMA.
module fma_operand_feeder #(
    parameter int FP       = 32,
    parameter int DEPTH    = 4,
    parameter int LEN_BITS = 4,
    parameter int TIMEOUT  = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push_in,
    input  logic [FP-1:0]       op_a_in,
    input  logic [FP-1:0]       op_b_in,
    input  logic [LEN_BITS-1:0] vec_len_in,
    output logic                full_out,
    fma_operand_feeder_if.master fma,
    output logic                result_valid_out,
    output logic [FP-1:0]       result_out,
    output logic                overflow_out,
    output logic                underflow_out,
    output logic                timeout_out,
    output logic                busy_out
);
    import fma_pkg::*;

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    feeder_state_e       state_r;
    feeder_state_e       state_s;
    logic                req_r;
    logic                req_s;
    logic                busy_r;
    logic                result_valid_r;
    logic [FP-1:0]       result_r;
    logic                ovf_r;
    logic                unf_r;
    logic                tmo_r;
    logic [LEN_BITS:0]   len_r;
    logic [LEN_BITS:0]   pair_cnt_r;
    logic [TW-1:0]       timer_r;
    logic                empty_s;
    logic                full_s;
    logic [2*FP-1:0]     head_s;
    logic                xfer_s;
    logic                answer_s;

    fma_operand_fifo #(
        .W     (2 * FP),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_in),
        .din   ({op_a_in, op_b_in}),
        .pop   (xfer_s),
        .full  (full_s),
        .empty (empty_s),
        .head  (head_s)
    );

    assign xfer_s   = req_r && !fma.fma_busy_in;
    assign answer_s = (state_r == WAIT) && fma.fma_ready_answer_in;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and next request; an answer on the timeout cycle takes priority
    always_comb begin
        state_s = state_r;
        req_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_s) state_s = ISSUE;
                else          state_s = IDLE;
            end
            ISSUE: begin
                if (xfer_s) state_s = WAIT;
                else        state_s = ISSUE;
                if (!empty_s && !xfer_s) req_s = 1'b1;
                else                     req_s = 1'b0;
            end
            WAIT: begin
                if (answer_s) begin
                    if (pair_cnt_r == len_r) state_s = DELIVER;
                    else                     state_s = ISSUE;
                end else if (timer_r == TMO_LAST) begin
                    state_s = ERROR;
                end else begin
                    state_s = WAIT;
                end
            end
            DELIVER: state_s = IDLE;
            ERROR:   state_s = ERROR;
            default: state_s = IDLE;
        endcase
    end

    // Registered outputs, counters and sticky flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_r          <= 1'b0;
            busy_r         <= 1'b0;
            result_valid_r <= 1'b0;
            result_r       <= {FP{1'b0}};
            ovf_r          <= 1'b0;
            unf_r          <= 1'b0;
            tmo_r          <= 1'b0;
            len_r          <= {(LEN_BITS+1){1'b0}};
            pair_cnt_r     <= {(LEN_BITS+1){1'b0}};
            timer_r        <= {TW{1'b0}};
        end else begin
            req_r          <= req_s;
            busy_r         <= (state_s != IDLE);
            result_valid_r <= (state_s == DELIVER);
            if ((state_r == IDLE) && (state_s == ISSUE)) begin
                len_r      <= (vec_len_in == {LEN_BITS{1'b0}}) ?
                              {{LEN_BITS{1'b0}}, 1'b1} : {1'b0, vec_len_in};
                pair_cnt_r <= {(LEN_BITS+1){1'b0}};
                ovf_r      <= 1'b0;
                unf_r      <= 1'b0;
            end else begin
                if (xfer_s) begin
                    pair_cnt_r <= pair_cnt_r + (LEN_BITS+1)'(1);
                end
                if (answer_s) begin
                    ovf_r <= ovf_r | fma.fma_overflow_in;
                    unf_r <= unf_r | fma.fma_underflow_in;
                end
            end
            if (xfer_s) begin
                timer_r <= {TW{1'b0}};
            end else if (state_r == WAIT) begin
                timer_r <= timer_r + TW'(1);
            end
            if (answer_s && (state_s == DELIVER)) begin
                result_r <= fma.fma_answer_in;
            end
            if (state_s == ERROR) begin
                tmo_r <= 1'b1;
            end
        end
    end

    assign full_out            = full_s;
    assign fma.float_0_req_out = req_r;
    assign fma.float_1_req_out = req_r;
    assign fma.float_0_out     = head_s[2*FP-1:FP];
    assign fma.float_1_out     = head_s[FP-1:0];
    assign result_valid_out    = result_valid_r;
    assign result_out          = result_r;
    assign overflow_out        = ovf_r;
    assign underflow_out       = unf_r;
    assign timeout_out         = tmo_r;
    assign busy_out            = busy_r;

endmodule
